// File: rtl/button_event_pkg.sv
// Shared encodings for the button event generator: FSM states, pulse vector layout, counter width.
package button_event_pkg;

    localparam logic [1:0] ST_WAIT_REL = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_HELD     = 2'd3;

    typedef enum logic [1:0] {
        WAIT_REL = ST_WAIT_REL,
        IDLE     = ST_IDLE,
        PRESSED  = ST_PRESSED,
        HELD     = ST_HELD
    } state_e;

    localparam int unsigned PULSE_PRESS   = 0;
    localparam int unsigned PULSE_RELEASE = 1;
    localparam int unsigned PULSE_SHORT   = 2;
    localparam int unsigned PULSE_LONG    = 3;
    localparam int unsigned PULSE_REPEAT  = 4;
    localparam int unsigned PULSE_W       = 5;

    localparam int unsigned PRESS_CNT_W = 8;

endpackage

// File: rtl/button_event_gen_cycle_timer.sv
// Shared sample counter: clear has priority over enable, hit_c flags the sample that reaches term.
module cycle_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             sat,
    input  logic [CNT_W-1:0] term,
    output logic             hit_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_inc;

    assign count_inc = count_q + CNT_W'(1);
    assign hit_c     = en && (count_inc == term);

    // Saturation only matters when nobody clears the timer at its terminal count.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !(sat && (count_q == term))) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/button_event_gen.sv
// Turns the debounced button level into press/release/short/long/repeat pulses and a press counter.
module button_event_gen
    import button_event_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clean,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES);

    state_e                 state_q, state_d;
    logic [PULSE_W-1:0]     pulse_q, pulse_d;
    logic                   held_q, held_d;
    logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;

    logic             tmr_clr;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_term;
    logic             tmr_hit_c;

    cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .sat   (!REPEAT_EN),
        .term  (tmr_term),
        .hit_c (tmr_hit_c)
    );

    // The timer counts high samples of the current press; it is zero whenever the FSM sits in IDLE.
    always_comb begin
        state_d       = state_q;
        pulse_d       = '0;
        held_d        = held_q;
        press_count_d = press_count_q;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;
        tmr_term      = HOLD_TERM;

        case (state_q)
            WAIT_REL: begin
                tmr_clr = 1'b1;
                if (!clean) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clean) begin
                    tmr_en                 = 1'b1;
                    state_d                = PRESSED;
                    pulse_d[PULSE_PRESS]   = 1'b1;
                    press_count_d          = press_count_q + PRESS_CNT_W'(1);
                end else begin
                    tmr_clr = 1'b1;
                end
            end
            PRESSED: begin
                if (clean) begin
                    tmr_en = 1'b1;
                    if (tmr_hit_c) begin
                        tmr_clr             = 1'b1;
                        state_d             = HELD;
                        pulse_d[PULSE_LONG] = 1'b1;
                        held_d              = 1'b1;
                    end
                end else begin
                    tmr_clr                = 1'b1;
                    state_d                = IDLE;
                    pulse_d[PULSE_RELEASE] = 1'b1;
                    pulse_d[PULSE_SHORT]   = 1'b1;
                end
            end
            HELD: begin
                tmr_term = REPEAT_TERM;
                if (clean) begin
                    tmr_en = 1'b1;
                    if (tmr_hit_c && REPEAT_EN) begin
                        tmr_clr               = 1'b1;
                        pulse_d[PULSE_REPEAT] = 1'b1;
                    end
                end else begin
                    tmr_clr                = 1'b1;
                    state_d                = IDLE;
                    pulse_d[PULSE_RELEASE] = 1'b1;
                    held_d                 = 1'b0;
                end
            end
            default: begin
                state_d = WAIT_REL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_REL;
            pulse_q       <= '0;
            held_q        <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pulse_q       <= pulse_d;
            held_q        <= held_d;
            press_count_q <= press_count_d;
        end
    end

    assign press_pulse   = pulse_q[PULSE_PRESS];
    assign release_pulse = pulse_q[PULSE_RELEASE];
    assign short_pulse   = pulse_q[PULSE_SHORT];
    assign long_pulse    = pulse_q[PULSE_LONG];
    assign repeat_pulse  = pulse_q[PULSE_REPEAT];
    assign held          = held_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench: a run-length model predicts each cycle's outputs for a repeat-enabled and a repeat-disabled DUT.
module tb_button_event_gen;

    localparam int unsigned HOLD = 8;
    localparam int unsigned REP  = 4;

    logic clk;
    logic rst_n;
    logic clean;

    logic       press0, rel0, short0, long0, rep0, held0;
    logic [7:0] cnt0;
    logic       press1, rel1, short1, long1, rep1, held1;
    logic [7:0] cnt1;

    button_event_gen #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .REPEAT_EN     (1'b1),
        .CNT_W         (8)
    ) dut_en (
        .clk           (clk),
        .rst_n         (rst_n),
        .clean         (clean),
        .press_pulse   (press0),
        .release_pulse (rel0),
        .short_pulse   (short0),
        .long_pulse    (long0),
        .repeat_pulse  (rep0),
        .held          (held0),
        .press_count   (cnt0)
    );

    button_event_gen #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .REPEAT_EN     (1'b0),
        .CNT_W         (8)
    ) dut_norep (
        .clk           (clk),
        .rst_n         (rst_n),
        .clean         (clean),
        .press_pulse   (press1),
        .release_pulse (rel1),
        .short_pulse   (short1),
        .long_pulse    (long1),
        .repeat_pulse  (rep1),
        .held          (held1),
        .press_count   (cnt1)
    );

    logic [13:0] obs0, obs1;
    assign obs0 = {press0, rel0, short0, long0, rep0, held0, cnt0};
    assign obs1 = {press1, rel1, short1, long1, rep1, held1, cnt1};

    int n_checks = 0;
    int n_errors = 0;
    string phase = "init";

    logic [13:0] sb_q0[$];
    logic [13:0] sb_q1[$];

    // model state, index 0 = repeat enabled, 1 = repeat disabled
    logic       m_armed[2];
    logic       m_down[2];
    int         m_run[2];
    logic [7:0] m_cnt[2];

    int t_long1, t_rep1, t_rep0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_armed[i] = 1'b0;
            m_down[i]  = 1'b0;
            m_run[i]   = 0;
            m_cnt[i]   = 8'd0;
        end
    endtask

    // Predicts outputs visible after the edge that samples c.
    task automatic model_step(input int i, input logic c, output logic [13:0] e);
        logic p, r, s, l, rp;
        p = 1'b0; r = 1'b0; s = 1'b0; l = 1'b0; rp = 1'b0;
        if (!m_armed[i]) begin
            if (!c) m_armed[i] = 1'b1;
        end else if (c) begin
            if (!m_down[i]) begin
                m_down[i] = 1'b1;
                p         = 1'b1;
                m_cnt[i]  = m_cnt[i] + 8'd1;
            end
            m_run[i]++;
            if (m_run[i] == int'(HOLD)) l = 1'b1;
            if (i == 0 && m_run[i] > int'(HOLD) && ((m_run[i] - int'(HOLD)) % int'(REP)) == 0) rp = 1'b1;
        end else if (m_down[i]) begin
            r         = 1'b1;
            s         = (m_run[i] < int'(HOLD));
            m_down[i] = 1'b0;
            m_run[i]  = 0;
        end
        e = {p, r, s, l, rp, (m_down[i] && m_run[i] >= int'(HOLD)), m_cnt[i]};
    endtask

    task automatic drive(input logic c, input int n);
        logic [13:0] e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            t_long1 += int'(long1);
            t_rep1  += int'(rep1);
            t_rep0  += int'(rep0);
            clean = c;
            model_step(0, c, e);
            sb_q0.push_back(e);
            model_step(1, c, e);
            sb_q1.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic do_reset(input logic c);
        @(negedge clk);
        clean = c;
        rst_n = 1'b0;
        #1;
        check_eq({phase, "/rst_en"}, 32'(obs0), 32'd0);
        check_eq({phase, "/rst_norep"}, 32'(obs1), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq({phase, "/rst_hold_en"}, 32'(obs0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard consumer: one expected entry per sampled edge.
    always @(posedge clk) begin
        logic [13:0] e;
        #1;
        if (sb_q0.size() != 0) begin
            e = sb_q0.pop_front();
            check_eq({phase, "/en"}, 32'(obs0), 32'(e));
        end
        if (sb_q1.size() != 0) begin
            e = sb_q1.pop_front();
            check_eq({phase, "/norep"}, 32'(obs1), 32'(e));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clean = 1'b0;
        rst_n = 1'b0;
        t_long1 = 0; t_rep1 = 0; t_rep0 = 0;
        model_reset();

        phase = "reset";
        do_reset(1'b0);
        drive(1'b0, 2);

        phase = "short3";
        drive(1'b1, 3);
        drive(1'b0, 3);

        phase = "hold20";
        drive(1'b1, 20);
        drive(1'b0, 3);

        phase = "exact8";
        drive(1'b1, 8);
        drive(1'b0, 2);
        phase = "exact7";
        drive(1'b1, 7);
        drive(1'b0, 2);

        phase = "held_thru_rst";
        do_reset(1'b1);
        drive(1'b1, 10);
        drive(1'b0, 1);
        drive(1'b1, 2);
        drive(1'b0, 2);
        @(negedge clk);
        check_eq("held_thru_rst/cnt", 32'(cnt0), 32'd1);

        phase = "wrap";
        do_reset(1'b0);
        drive(1'b0, 1);
        for (int k = 0; k < 256; k++) begin
            drive(1'b1, 1);
            drive(1'b0, 1);
        end
        @(negedge clk);
        check_eq("wrap/cnt", 32'(cnt0), 32'd0);

        phase = "rst_in_held";
        drive(1'b1, 15);
        @(negedge clk);
        check_eq("rst_in_held/held_before", 32'(held0), 32'd1);
        do_reset(1'b1);
        drive(1'b1, 3);
        drive(1'b0, 2);

        phase = "hold40";
        drive(1'b0, 1);
        t_long1 = 0; t_rep1 = 0; t_rep0 = 0;
        drive(1'b1, 40);
        drive(1'b0, 2);
        check_eq("hold40/norep_long", 32'(t_long1), 32'd1);
        check_eq("hold40/norep_repeat", 32'(t_rep1), 32'd0);
        check_eq("hold40/en_repeat", 32'(t_rep0), 32'd8);

        #2;
        check_eq("sb_drain", 32'(sb_q0.size() + sb_q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
